// File: rtl/toy_ldq_pkg.sv
// Shared types for the load queue: LSU payload, default depth and per-entry state.
package toy_pack;

  localparam int LDU_DEPTH = 8;

  typedef struct packed {
    logic [3:0]  tag;
    logic [15:0] addr;
  } lsu_pkg;

  typedef enum logic [1:0] {
    ENT_FREE,
    ENT_WAIT,
    ENT_ISSUED,
    ENT_DONE
  } ldq_state_e;

endpackage

// File: rtl/toy_ldq_credit.sv
// Credit return to the LSU buffer, one credit per retired load.
// TOY_LDQ_CREDIT_COALESCE_EN batches credits until four accumulate or a retire-free cycle.
module toy_ldq_credit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cancel_en,
  input  logic       retire,
  output logic       ldu_credit_en,
  output logic [3:0] ldu_credit_num
);

`ifdef TOY_LDQ_CREDIT_COALESCE_EN
  logic [3:0] acc_q;
  logic [3:0] sum;

  assign sum = acc_q + 4'(retire);

  always_ff @(posedge clk) begin
    if (rst_n || cancel_en) begin
      acc_q          <= '0;
      ldu_credit_en  <= 1'b0;
      ldu_credit_num <= '0;
    end else if ((retire && sum >= 4'd4) || (!retire && acc_q != '0)) begin
      acc_q          <= '0;
      ldu_credit_en  <= 1'b1;
      ldu_credit_num <= sum;
    end else begin
      acc_q          <= sum;
      ldu_credit_en  <= 1'b0;
      ldu_credit_num <= '0;
    end
  end
`else
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n || cancel_en) begin
      ldu_credit_en  <= 1'b0;
      ldu_credit_num <= '0;
    end else begin
      ldu_credit_en  <= retire;
      ldu_credit_num <= {3'b000, retire};
    end
  end
`endif

endmodule

// File: rtl/toy_ldq.sv
// Two-lane load queue: in-order dcache issue, in-order response fill, in-order writeback.
// Credit batching is selected with TOY_LDQ_CREDIT_COALESCE_EN (see toy_ldq_credit).
module toy_ldq
  import toy_pack::*;
#(
  parameter int DEPTH = LDU_DEPTH,
  parameter int RSP_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ldu_vld,
  input  lsu_pkg [1:0]     ldu_pld,
  output logic [1:0]       ldq_rdy,
  output logic             dc_req_vld,
  output lsu_pkg           dc_req_pld,
  input  logic             dc_req_rdy,
  input  logic             dc_rsp_vld,
  input  logic [RSP_W-1:0] dc_rsp_data,
  output logic             wb_vld,
  output lsu_pkg           wb_pld,
  output logic [RSP_W-1:0] wb_data,
  input  logic             wb_rdy,
  input  logic             cancel_en,
  output logic             ldu_credit_en,
  output logic [3:0]       ldu_credit_num
);

  localparam int DEPTH_W = $clog2(DEPTH);
  localparam logic [DEPTH_W:0] DEPTH_V = (DEPTH_W+1)'(DEPTH);

  ldq_state_e       st_q   [DEPTH];
  lsu_pkg           pld_q  [DEPTH];
  logic [RSP_W-1:0] data_q [DEPTH];

  logic [DEPTH_W-1:0] head_q, iss_q, tail_q, tail1, rsp_idx;
  logic [DEPTH_W:0]   occ, out_cnt, free;
  logic [DEPTH_W+1:0] drop_cnt, pend, drop_load;
  logic               acc0, acc1, issue, rsp_take, retire;

  assign free    = DEPTH_V - occ;
  assign ldq_rdy = {free >= (DEPTH_W+1)'(2), free >= (DEPTH_W+1)'(1)};

  // Flush outranks everything, so no handshake is offered in a cancel cycle.
  assign acc0     = ldu_vld[0] & ldq_rdy[0] & ~cancel_en;
  assign acc1     = ldu_vld[1] & ldq_rdy[1] & acc0;
  assign tail1    = tail_q + DEPTH_W'(1);

  assign dc_req_vld = (st_q[iss_q] == ENT_WAIT) & ~cancel_en;
  assign dc_req_pld = pld_q[iss_q];
  assign issue      = dc_req_vld & dc_req_rdy;

  // Responses return in issue order, so the oldest issued entry sits out_cnt behind iss_q.
  assign rsp_idx  = iss_q - out_cnt[DEPTH_W-1:0];
  assign rsp_take = dc_rsp_vld & (drop_cnt == '0) & ~cancel_en;

  assign wb_vld  = (st_q[head_q] == ENT_DONE) & ~cancel_en;
  assign wb_pld  = pld_q[head_q];
  assign wb_data = data_q[head_q];
  assign retire  = wb_vld & wb_rdy;

  // A response arriving with the flush consumes one of the pending replies.
  assign pend      = drop_cnt + (DEPTH_W+2)'(out_cnt);
  assign drop_load = (dc_rsp_vld && pend != '0) ? pend - (DEPTH_W+2)'(1) : pend;

  always_ff @(posedge clk) begin
    if (rst_n || cancel_en) begin
      head_q   <= '0;
      iss_q    <= '0;
      tail_q   <= '0;
      occ      <= '0;
      out_cnt  <= '0;
      drop_cnt <= rst_n ? '0 : drop_load;
      for (int i = 0; i < DEPTH; i++) st_q[i] <= ENT_FREE;
    end else begin
      if (acc0)     st_q[tail_q]  <= ENT_WAIT;
      if (acc1)     st_q[tail1]   <= ENT_WAIT;
      if (issue)    st_q[iss_q]   <= ENT_ISSUED;
      if (rsp_take) st_q[rsp_idx] <= ENT_DONE;
      if (retire)   st_q[head_q]  <= ENT_FREE;

      tail_q  <= tail_q + DEPTH_W'(acc0) + DEPTH_W'(acc1);
      iss_q   <= iss_q + DEPTH_W'(issue);
      head_q  <= head_q + DEPTH_W'(retire);
      occ     <= occ + (DEPTH_W+1)'(acc0) + (DEPTH_W+1)'(acc1) - (DEPTH_W+1)'(retire);
      out_cnt <= out_cnt + (DEPTH_W+1)'(issue) - (DEPTH_W+1)'(rsp_take);
      if (dc_rsp_vld && drop_cnt != '0) drop_cnt <= drop_cnt - (DEPTH_W+2)'(1);
    end
  end

  // NOTE: payload/data arrays carry no reset; entry state alone decides whether contents are live.
  always_ff @(posedge clk) begin
    if (acc0)     pld_q[tail_q]   <= ldu_pld[0];
    if (acc1)     pld_q[tail1]    <= ldu_pld[1];
    if (rsp_take) data_q[rsp_idx] <= dc_rsp_data;
  end

  toy_ldq_credit u_credit (
    .clk            (clk),
    .rst_n          (rst_n),
    .cancel_en      (cancel_en),
    .retire         (retire),
    .ldu_credit_en  (ldu_credit_en),
    .ldu_credit_num (ldu_credit_num)
  );

  a_lane1_alone: assert property (@(posedge clk) disable iff (rst_n) !(ldu_vld[1] && !ldu_vld[0]))
    else $error("ldu_vld[1] asserted without ldu_vld[0]");
  a_accept_full: assert property (@(posedge clk) disable iff (rst_n) !(acc0 && occ == DEPTH_V))
    else $error("load accepted while queue full");
  a_rsp_orphan: assert property (@(posedge clk) disable iff (rst_n)
                                 !(dc_rsp_vld && out_cnt == '0 && drop_cnt == '0))
    else $error("dcache response with nothing outstanding");

endmodule

// File: tb/tb_toy_ldq.sv
// Self-checking bench for toy_ldq: directed scenarios plus random traffic against a queue-level model.
module tb_toy_ldq;
  import toy_pack::*;

  localparam int DEPTH   = LDU_DEPTH;
  localparam int DEPTH_W = $clog2(DEPTH);
  localparam int RSP_W   = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [1:0]       ldu_vld = '0;
  lsu_pkg [1:0]     ldu_pld = '0;
  logic [1:0]       ldq_rdy;
  logic             dc_req_vld;
  lsu_pkg           dc_req_pld;
  logic             dc_req_rdy = 1'b0;
  logic             dc_rsp_vld = 1'b0;
  logic [RSP_W-1:0] dc_rsp_data = '0;
  logic             wb_vld;
  lsu_pkg           wb_pld;
  logic [RSP_W-1:0] wb_data;
  logic             wb_rdy = 1'b0;
  logic             cancel_en = 1'b0;
  logic             ldu_credit_en;
  logic [3:0]       ldu_credit_num;

  toy_ldq #(.DEPTH(DEPTH), .RSP_W(RSP_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ldu_vld        (ldu_vld),
    .ldu_pld        (ldu_pld),
    .ldq_rdy        (ldq_rdy),
    .dc_req_vld     (dc_req_vld),
    .dc_req_pld     (dc_req_pld),
    .dc_req_rdy     (dc_req_rdy),
    .dc_rsp_vld     (dc_rsp_vld),
    .dc_rsp_data    (dc_rsp_data),
    .wb_vld         (wb_vld),
    .wb_pld         (wb_pld),
    .wb_data        (wb_data),
    .wb_rdy         (wb_rdy),
    .cancel_en      (cancel_en),
    .ldu_credit_en  (ldu_credit_en),
    .ldu_credit_num (ldu_credit_num)
  );

  always #5 clk = ~clk;

  // Model: program-order list of live loads; st 0 = waiting, 1 = sent to dcache, 2 = data back.
  typedef struct {
    lsu_pkg           pld;
    logic [RSP_W-1:0] data;
    int               st;
  } ment_t;

  ment_t      mq[$];
  int         drop;
  int         dc_pend;
  int         m_acc;
  logic       m_cred_en;
  logic [3:0] m_cred_num;
  int         seq;
  int         tests;
  int         fails;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int n_issued();
    int n = 0;
    foreach (mq[i]) if (mq[i].st == 1) n++;
    return n;
  endfunction

  function automatic bit all_done();
    foreach (mq[i]) if (mq[i].st != 2) return 1'b0;
    return 1'b1;
  endfunction

  function automatic lsu_pkg new_pld();
    lsu_pkg p;
    seq++;
    p.tag  = 4'(seq);
    p.addr = 16'($urandom);
    return p;
  endfunction

  // Compare outputs with the model for the current inputs, then advance both by one clock.
  task automatic step();
    int         free, wi, ri, n;
    logic [1:0] e_rdy;
    logic       e_req, e_wb, ret, iss;
    #1;
    free  = DEPTH - mq.size();
    e_rdy = {free >= 2, free >= 1};
    wi = -1;
    for (int i = 0; i < mq.size(); i++) if (mq[i].st == 0) begin wi = i; break; end
    e_req = (wi >= 0) && !cancel_en;
    e_wb  = (mq.size() > 0) && (mq[0].st == 2) && !cancel_en;

    check("ldq_rdy", 64'(ldq_rdy), 64'(e_rdy));
    check("dc_req_vld", 64'(dc_req_vld), 64'(e_req));
    if (e_req) check("dc_req_pld", 64'(dc_req_pld), 64'(mq[wi].pld));
    check("wb_vld", 64'(wb_vld), 64'(e_wb));
    if (e_wb) begin
      check("wb_pld", 64'(wb_pld), 64'(mq[0].pld));
      check("wb_data", 64'(wb_data), 64'(mq[0].data));
    end
    check("credit_en", 64'(ldu_credit_en), 64'(m_cred_en));
    check("credit_num", 64'(ldu_credit_num), 64'(m_cred_num));

    ret = e_wb && wb_rdy;
    iss = e_req && dc_req_rdy;
    if (cancel_en) begin
      n = drop + n_issued();
      if (dc_rsp_vld && n > 0) n--;
      drop = n;
      mq.delete();
      m_acc      = 0;
      m_cred_en  = 1'b0;
      m_cred_num = '0;
    end else begin
      if (dc_rsp_vld) begin
        if (drop > 0) drop--;
        else begin
          ri = -1;
          for (int i = 0; i < mq.size(); i++) if (mq[i].st == 1) begin ri = i; break; end
          if (ri >= 0) begin
            mq[ri].st   = 2;
            mq[ri].data = dc_rsp_data;
          end
        end
      end
      if (iss) mq[wi].st = 1;
      if (ret) void'(mq.pop_front());
      if (ldu_vld[0] && e_rdy[0]) mq.push_back('{pld: ldu_pld[0], data: '0, st: 0});
      if (ldu_vld[0] && ldu_vld[1] && e_rdy[1]) mq.push_back('{pld: ldu_pld[1], data: '0, st: 0});
`ifdef TOY_LDQ_CREDIT_COALESCE_EN
      if (ret) m_acc++;
      if ((ret && m_acc >= 4) || (!ret && m_acc > 0)) begin
        m_cred_en  = 1'b1;
        m_cred_num = 4'(m_acc);
        m_acc      = 0;
      end else begin
        m_cred_en  = 1'b0;
        m_cred_num = '0;
      end
`else
      m_cred_en  = ret;
      m_cred_num = ret ? 4'd1 : 4'd0;
`endif
    end
    if (iss) dc_pend++;
    if (dc_rsp_vld && dc_pend > 0) dc_pend--;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ldu_vld    = '0;
    dc_req_rdy = 1'b0;
    dc_rsp_vld = 1'b0;
    wb_rdy     = 1'b0;
    cancel_en  = 1'b0;
  endtask

  // The dcache is reset alongside, so anything it still owed is forgotten too.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    mq.delete();
    drop       = 0;
    dc_pend    = 0;
    m_acc      = 0;
    m_cred_en  = 1'b0;
    m_cred_num = '0;
  endtask

  task automatic alloc(input logic [1:0] v);
    ldu_vld    = v;
    ldu_pld[0] = new_pld();
    ldu_pld[1] = new_pld();
    step();
    ldu_vld = '0;
  endtask

  task automatic settle_done(input string tag);
    int n = 0;
    ldu_vld    = '0;
    wb_rdy     = 1'b0;
    dc_req_rdy = 1'b1;
    while (!(all_done() && dc_pend == 0) && n < 200) begin
      dc_rsp_vld  = dc_pend > 0;
      dc_rsp_data = $urandom;
      step();
      n++;
    end
    dc_rsp_vld = 1'b0;
    dc_req_rdy = 1'b0;
    check({tag, "_bound"}, 64'(n < 200), 64'(1));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    ldu_vld    = '0;
    cancel_en  = 1'b0;
    dc_req_rdy = 1'b1;
    wb_rdy     = 1'b1;
    while ((mq.size() > 0 || dc_pend > 0) && n < 200) begin
      dc_rsp_vld  = dc_pend > 0;
      dc_rsp_data = $urandom;
      step();
      n++;
    end
    idle_inputs();
    check({tag, "_bound"}, 64'(n < 200), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  initial begin
    int left;
    tests = 0;
    fails = 0;
    seq   = 0;

    // Reset state
    do_reset();
    check("rst_rdy", 64'(ldq_rdy), 64'(2'b11));
    check("rst_req", 64'(dc_req_vld), 64'(0));
    check("rst_wb", 64'(wb_vld), 64'(0));
    check("rst_cred_en", 64'(ldu_credit_en), 64'(0));
    check("rst_cred_num", 64'(ldu_credit_num), 64'(0));
    step();

    // Single load latency: request next cycle, writeback after response, credit after retire
    dc_req_rdy = 1'b1;
    wb_rdy     = 1'b1;
    alloc(2'b01);
    check("lat_req_c1", 64'(dc_req_vld), 64'(1));
    step();
    step();
    dc_rsp_vld  = 1'b1;
    dc_rsp_data = 32'hA5A5_0001;
    step();
    dc_rsp_vld = 1'b0;
    check("lat_wb_c4", 64'(wb_vld), 64'(1));
    check("lat_wb_data", 64'(wb_data), 64'(32'hA5A5_0001));
    step();
`ifndef TOY_LDQ_CREDIT_COALESCE_EN
    check("lat_cred_en_c5", 64'(ldu_credit_en), 64'(1));
    check("lat_cred_num_c5", 64'(ldu_credit_num), 64'(1));
`endif
    idle_inputs();
    repeat (3) step();

    // Fill to full with dual-lane dispatch, then retire + alloc in the same cycle
    do_reset();
    for (int i = 0; i < DEPTH / 2; i++) alloc(2'b11);
    check("full_rdy", 64'(ldq_rdy), 64'(2'b00));
    check("full_occ", 64'(dut.occ), 64'(DEPTH));
    settle_done("full_settle");
    wb_rdy     = 1'b1;
    ldu_vld    = 2'b01;
    ldu_pld[0] = new_pld();
    step();
    ldu_vld = '0;
    wb_rdy  = 1'b0;
    check("full_retire_occ", 64'(dut.occ), 64'(DEPTH - 1));
    check("full_retire_rdy", 64'(ldq_rdy), 64'(2'b01));
    drain("full_drain");

    // Tail wrap from DEPTH-1 with a two-lane accept
    do_reset();
    left = DEPTH - 1;
    while (left > 0) begin
      if (left >= 2) begin alloc(2'b11); left -= 2; end
      else begin alloc(2'b01); left--; end
    end
    drain("wrap_pre");
    alloc(2'b11);
    check("wrap_tail", 64'(dut.tail_q), 64'((DEPTH + 1) % DEPTH));
    check("wrap_occ", 64'(dut.occ), 64'(2));
    drain("wrap_drain");

    // Flush with two requests outstanding: both late responses are dropped
    do_reset();
    alloc(2'b11);
    dc_req_rdy = 1'b1;
    step();
    step();
    dc_req_rdy = 1'b0;
    cancel_en  = 1'b1;
    step();
    cancel_en = 1'b0;
    check("cancel_occ", 64'(dut.occ), 64'(0));
    check("cancel_cred", 64'(ldu_credit_en), 64'(0));
    dc_rsp_vld = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dc_rsp_data = $urandom;
      step();
      check("cancel_wb", 64'(wb_vld), 64'(0));
      check("cancel_cred_en", 64'(ldu_credit_en), 64'(0));
    end
    dc_rsp_vld = 1'b0;
    step();
    check("cancel_wb_after", 64'(wb_vld), 64'(0));
    alloc(2'b01);
    drain("cancel_reuse");

    // Five back-to-back retires followed by an idle cycle
    do_reset();
    for (int i = 0; i < 3; i++) alloc(2'b11);
    settle_done("cred_settle");
    wb_rdy = 1'b1;
    for (int i = 0; i < 4; i++) step();
`ifdef TOY_LDQ_CREDIT_COALESCE_EN
    check("coal_en_4", 64'(ldu_credit_en), 64'(1));
    check("coal_num_4", 64'(ldu_credit_num), 64'(4));
`else
    check("cred_en_4", 64'(ldu_credit_en), 64'(1));
    check("cred_num_4", 64'(ldu_credit_num), 64'(1));
`endif
    step();
    wb_rdy = 1'b0;
    step();
`ifdef TOY_LDQ_CREDIT_COALESCE_EN
    check("coal_en_1", 64'(ldu_credit_en), 64'(1));
    check("coal_num_1", 64'(ldu_credit_num), 64'(1));
`else
    check("cred_en_idle", 64'(ldu_credit_en), 64'(0));
`endif
    drain("cred_drain");

    // Random traffic with occasional flushes and one reset mid-stream
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      case ($urandom_range(2))
        0:       ldu_vld = 2'b00;
        1:       ldu_vld = 2'b01;
        default: ldu_vld = 2'b11;
      endcase
      ldu_pld[0]  = new_pld();
      ldu_pld[1]  = new_pld();
      dc_req_rdy  = 1'($urandom_range(1));
      dc_rsp_vld  = (dc_pend > 0) && ($urandom_range(2) != 0);
      dc_rsp_data = $urandom;
      wb_rdy      = 1'($urandom_range(1));
      cancel_en   = ($urandom_range(39) == 0);
      step();
    end
    drain("rand_drain");
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
